// File: rtl/urv_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// mcause codes, CSR bit positions and the controller FSM encoding.
package urv_trap_ctrl_pkg;

  localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ID_MIE     = 12'h304;
  localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ID_MIP     = 12'h344;

  localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] MCAUSE_ECALL   = 4'd11;
  localparam logic [3:0] MCAUSE_MEI     = 4'd11;
  localparam logic [3:0] MCAUSE_MTI     = 4'd7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIE_MTIE_BIT     = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } trap_state_e;

  // mcause layout: interrupt flag in the MSB, 4-bit exception/interrupt code at the bottom.
  function automatic logic [31:0] mcause_value(input logic irq, input logic [3:0] code);
    return {irq, 27'h0, code};
  endfunction

endpackage

// File: rtl/urv_trap_ctrl_if.sv
// X-stage side of the trap controller: pipeline control in, redirect and
// CSR read values out. The pipeline is the master, the trap controller the slave.
interface urv_trap_ctrl_if;

  logic        x_stall_i;
  logic        x_kill_i;
  logic        x_valid_i;
  logic [31:0] x_pc_i;
  logic        x_exception_i;
  logic [3:0]  x_exception_cause_i;
  logic        x_is_mret_i;
  logic        d_is_csr_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i;

  logic        x_redirect_o;
  logic [31:0] x_redirect_pc_o;
  logic        x_irq_taken_o;
  logic [31:0] csr_mstatus_o;
  logic [31:0] csr_mie_o;
  logic [31:0] csr_mip_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mcause_o;

  modport master (
    output x_stall_i, x_kill_i, x_valid_i, x_pc_i, x_exception_i,
           x_exception_cause_i, x_is_mret_i, d_is_csr_i, d_csr_sel_i,
           x_csr_write_value_i,
    input  x_redirect_o, x_redirect_pc_o, x_irq_taken_o, csr_mstatus_o,
           csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o
  );

  modport slave (
    input  x_stall_i, x_kill_i, x_valid_i, x_pc_i, x_exception_i,
           x_exception_cause_i, x_is_mret_i, d_is_csr_i, d_csr_sel_i,
           x_csr_write_value_i,
    output x_redirect_o, x_redirect_pc_o, x_irq_taken_o, csr_mstatus_o,
           csr_mie_o, csr_mip_o, csr_mepc_o, csr_mcause_o
  );

endinterface

// File: rtl/urv_irq_sync.sv
// Multi-flop synchronizer for one asynchronous level interrupt line.
module urv_irq_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [DEPTH-1:0] chain_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its predecessor held before this edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) chain_q <= '0;
    else        chain_q <= {chain_q[DEPTH-2:0], async_i};
  end

  assign sync_o = chain_q[DEPTH-1];

endmodule

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap controller: owns mstatus/mie/mip/mepc/mcause, arbitrates
// exceptions, interrupts, MRET and CSR writes in X, and strobes PC redirects.
module urv_trap_ctrl
  import urv_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0008,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           irq_ext_i,
  input  logic           irq_timer_i,
  urv_trap_ctrl_if.slave x
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  logic meip, mtip;

  urv_irq_sync #(.DEPTH(SYNC_STAGES)) u_sync_ext (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (irq_ext_i),
    .sync_o  (meip)
  );

  urv_irq_sync #(.DEPTH(SYNC_STAGES)) u_sync_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (irq_timer_i),
    .sync_o  (mtip)
  );

  logic        mie_q, mpie_q, meie_q, mtie_q;
  logic [31:0] mepc_q, mcause_q;
  trap_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Event arbitration: exactly one of trap / mret / csr acts in an enabled cycle.
  logic en, pend, exc_act, irq_act, trap_act, mret_act, csr_act, redirect_req;

  assign en       = !x.x_stall_i && !x.x_kill_i;
  assign pend     = mie_q && ((meip && meie_q) || (mtip && mtie_q));
  assign exc_act  = en && x.x_exception_i;
  assign irq_act  = en && !x.x_exception_i && pend && x.x_valid_i && (state_q == ST_IDLE);
  assign trap_act = exc_act || irq_act;
  assign mret_act = en && !trap_act && x.x_is_mret_i;
  assign csr_act  = en && !trap_act && !x.x_is_mret_i && x.d_is_csr_i;
  assign redirect_req = trap_act || mret_act;

  // Strobes are gated by reset so they drop the moment reset asserts, not at the next edge.
  assign x.x_redirect_o    = redirect_req && rst_i;
  assign x.x_irq_taken_o   = irq_act && rst_i;
  assign x.x_redirect_pc_o = !x.x_redirect_o ? 32'h0 :
                             trap_act        ? TRAP_VECTOR : mepc_q;

  // FSM next state: FLUSH lasts FLUSH_CYCLES clocks after the latest redirect.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (redirect_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // CSR register file; only one of the branches below fires per cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_act) begin
      mepc_q   <= x.x_pc_i & ~32'h3;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      mcause_q <= exc_act ? mcause_value(1'b0, x.x_exception_cause_i)
                          : mcause_value(1'b1, (meip && meie_q) ? MCAUSE_MEI : MCAUSE_MTI);
    end else if (mret_act) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_act) begin
      unique case (x.d_csr_sel_i)
        CSR_ID_MSTATUS: begin
          mie_q  <= x.x_csr_write_value_i[MSTATUS_MIE_BIT];
          mpie_q <= x.x_csr_write_value_i[MSTATUS_MPIE_BIT];
        end
        CSR_ID_MIE: begin
          meie_q <= x.x_csr_write_value_i[MIE_MEIE_BIT];
          mtie_q <= x.x_csr_write_value_i[MIE_MTIE_BIT];
        end
        CSR_ID_MEPC:   mepc_q   <= x.x_csr_write_value_i & ~32'h3;
        CSR_ID_MCAUSE: mcause_q <= mcause_value(x.x_csr_write_value_i[31],
                                                x.x_csr_write_value_i[3:0]);
        default: ;
      endcase
    end
  end

  always_comb begin
    x.csr_mstatus_o = '0;
    x.csr_mstatus_o[MSTATUS_MIE_BIT]  = mie_q;
    x.csr_mstatus_o[MSTATUS_MPIE_BIT] = mpie_q;
    x.csr_mie_o = '0;
    x.csr_mie_o[MIE_MEIE_BIT] = meie_q;
    x.csr_mie_o[MIE_MTIE_BIT] = mtie_q;
    x.csr_mip_o = '0;
    x.csr_mip_o[MIE_MEIE_BIT] = meip;
    x.csr_mip_o[MIE_MTIE_BIT] = mtip;
  end

  assign x.csr_mepc_o   = mepc_q;
  assign x.csr_mcause_o = mcause_q;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Self-checking bench for urv_trap_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the trap rules.
module tb_urv_trap_ctrl;

  localparam int          S  = 2;
  localparam int          F  = 2;
  localparam logic [31:0] TV = 32'h0000_0008;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic irq_ext = 1'b0;
  logic irq_timer = 1'b0;

  always #5 clk = ~clk;

  urv_trap_ctrl_if bus ();

  urv_trap_ctrl #(.TRAP_VECTOR(TV), .SYNC_STAGES(S), .FLUSH_CYCLES(F)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .irq_ext_i   (irq_ext),
    .irq_timer_i (irq_timer),
    .x           (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (architectural view only).
  logic        m_mie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mepc, m_mcause;
  int          m_flush_left;
  logic [S-1:0] ext_hist, tmr_hist;

  logic        obs_redir, obs_taken;
  logic [31:0] obs_pc;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    bus.x_stall_i           = 1'b0;
    bus.x_kill_i            = 1'b0;
    bus.x_valid_i           = 1'b0;
    bus.x_pc_i              = 32'h0;
    bus.x_exception_i       = 1'b0;
    bus.x_exception_cause_i = 4'h0;
    bus.x_is_mret_i         = 1'b0;
    bus.d_is_csr_i          = 1'b0;
    bus.d_csr_sel_i         = 12'h0;
    bus.x_csr_write_value_i = 32'h0;
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
    m_mepc = 0; m_mcause = 0; m_flush_left = 0;
    ext_hist = '0; tmr_hist = '0;
  endtask

  task automatic chk_csrs(input string pfx);
    logic meip, mtip;
    meip = ext_hist[S-1];
    mtip = tmr_hist[S-1];
    chk({pfx, "_mstatus"}, bus.csr_mstatus_o, (32'(m_mpie) << 7) | (32'(m_mie) << 3));
    chk({pfx, "_mie"},     bus.csr_mie_o,     (32'(m_meie) << 11) | (32'(m_mtie) << 7));
    chk({pfx, "_mip"},     bus.csr_mip_o,     (32'(meip) << 11) | (32'(mtip) << 7));
    chk({pfx, "_mepc"},    bus.csr_mepc_o,    m_mepc);
    chk({pfx, "_mcause"},  bus.csr_mcause_o,  m_mcause);
  endtask

  // One clock cycle: inputs already driven in the low phase; check, then advance model.
  task automatic cycle();
    logic meip, mtip, en, pend, exc, irq, mret, csr;
    logic [31:0] wd, exp_pc;
    #1;
    meip = ext_hist[S-1];
    mtip = tmr_hist[S-1];
    en   = !bus.x_stall_i && !bus.x_kill_i;
    pend = m_mie && ((meip && m_meie) || (mtip && m_mtie));
    exc  = en && bus.x_exception_i;
    irq  = en && !bus.x_exception_i && pend && bus.x_valid_i && (m_flush_left == 0);
    mret = en && !exc && !irq && bus.x_is_mret_i;
    csr  = en && !exc && !irq && !mret && bus.d_is_csr_i;
    exp_pc = (exc || irq) ? TV : m_mepc;

    obs_redir = bus.x_redirect_o;
    obs_taken = bus.x_irq_taken_o;
    obs_pc    = bus.x_redirect_pc_o;
    chk("redirect", 32'(obs_redir), 32'(exc || irq || mret));
    chk("irq_taken", 32'(obs_taken), 32'(irq));
    if (exc || irq || mret) chk("redirect_pc", obs_pc, exp_pc);
    chk_csrs("cyc");

    wd = bus.x_csr_write_value_i;
    @(posedge clk);
    if (exc || irq) begin
      m_mepc   = {bus.x_pc_i[31:2], 2'b00};
      m_mpie   = m_mie;
      m_mie    = 1'b0;
      m_mcause = exc ? {28'h0, bus.x_exception_cause_i}
                     : ((meip && m_meie) ? 32'h8000_000B : 32'h8000_0007);
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end else if (csr) begin
      case (bus.d_csr_sel_i)
        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h304: begin m_meie = wd[11]; m_mtie = wd[7]; end
        12'h341: m_mepc = {wd[31:2], 2'b00};
        12'h342: m_mcause = {wd[31], 27'h0, wd[3:0]};
        default: ;
      endcase
    end
    if (exc || irq || mret)    m_flush_left = F;
    else if (m_flush_left > 0) m_flush_left--;
    ext_hist = {ext_hist[S-2:0], irq_ext};
    tmr_hist = {tmr_hist[S-2:0], irq_timer};
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
    bus.d_is_csr_i = 1'b1;
    bus.d_csr_sel_i = sel;
    bus.x_csr_write_value_i = val;
    cycle();
    bus.d_is_csr_i = 1'b0;
  endtask

  // Run cycles until a redirect is seen or the bound expires; returns cycles used.
  task automatic run_until_redirect(input int bound, output int used);
    used = 0;
    do begin
      cycle();
      used++;
    end while (!obs_redir && used < bound);
  endtask

  int n;
  logic [11:0] sels [6] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h7C0};

  initial begin
    clear_inputs();
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_redirect", 32'(bus.x_redirect_o), 32'h0);
    chk_csrs("reset");
    rst_i = 1'b1;
    repeat (2) cycle();

    // External IRQ entry
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    chk("mie_wr", bus.csr_mie_o, 32'h800);
    chk("mstatus_wr", bus.csr_mstatus_o, 32'h8);
    irq_ext = 1'b1;
    bus.x_valid_i = 1'b1;
    bus.x_pc_i = 32'h100;
    run_until_redirect(10, n);
    chk("ext_latency", 32'(n), 32'(S + 1));
    chk("ext_redirect_pc", obs_pc, 32'h8);
    chk("ext_taken", 32'(obs_taken), 32'h1);
    chk("ext_mepc", bus.csr_mepc_o, 32'h100);
    chk("ext_mcause", bus.csr_mcause_o, 32'h8000_000B);
    chk("ext_mstatus", bus.csr_mstatus_o, 32'h80);

    // MRET back, IRQ held off during flush and then retaken
    bus.x_pc_i = 32'h104;
    bus.x_is_mret_i = 1'b1;
    cycle();
    bus.x_is_mret_i = 1'b0;
    chk("mret_redirect", 32'(obs_redir), 32'h1);
    chk("mret_pc", obs_pc, 32'h100);
    chk("mret_mstatus", bus.csr_mstatus_o, 32'h88);
    run_until_redirect(10, n);
    chk("retake_delay", 32'(n), 32'(F + 1));
    chk("retake_taken", 32'(obs_taken), 32'h1);
    irq_ext = 1'b0;
    bus.x_is_mret_i = 1'b1;
    cycle();
    bus.x_is_mret_i = 1'b0;
    repeat (3) cycle();

    // Exception and timer IRQ together: exception wins, timer taken later
    csr_write(12'h304, 32'h80);
    irq_timer = 1'b1;
    bus.x_valid_i = 1'b0;
    repeat (3) cycle();
    bus.x_valid_i = 1'b1;
    bus.x_pc_i = 32'h200;
    bus.x_exception_i = 1'b1;
    bus.x_exception_cause_i = 4'd2;
    cycle();
    bus.x_exception_i = 1'b0;
    chk("exc_irq_redirect", 32'(obs_redir), 32'h1);
    chk("exc_irq_taken", 32'(obs_taken), 32'h0);
    chk("exc_mcause", bus.csr_mcause_o, 32'h2);
    bus.x_is_mret_i = 1'b1;
    cycle();
    bus.x_is_mret_i = 1'b0;
    chk("exc_mret_pc", obs_pc, 32'h200);
    run_until_redirect(10, n);
    chk("timer_taken", 32'(obs_taken), 32'h1);
    chk("timer_mcause", bus.csr_mcause_o, 32'h8000_0007);
    irq_timer = 1'b0;
    repeat (3) cycle();

    // Stall and kill suppress an exception; release takes it
    bus.x_pc_i = 32'h300;
    bus.x_exception_i = 1'b1;
    bus.x_exception_cause_i = 4'd11;
    bus.x_stall_i = 1'b1;
    cycle();
    chk("stall_redirect", 32'(obs_redir), 32'h0);
    chk("stall_mepc", bus.csr_mepc_o, 32'h200);
    bus.x_stall_i = 1'b0;
    bus.x_kill_i = 1'b1;
    cycle();
    chk("kill_redirect", 32'(obs_redir), 32'h0);
    chk("kill_mepc", bus.csr_mepc_o, 32'h200);
    bus.x_kill_i = 1'b0;
    cycle();
    bus.x_exception_i = 1'b0;
    chk("release_redirect", 32'(obs_redir), 32'h1);
    chk("release_mepc", bus.csr_mepc_o, 32'h300);
    chk("release_mcause", bus.csr_mcause_o, 32'hB);

    // CSR write masking
    csr_write(12'h344, 32'hFFFF_FFFF);
    chk("mip_ro", bus.csr_mip_o, 32'h0);
    csr_write(12'h341, 32'h103);
    chk("mepc_align", bus.csr_mepc_o, 32'h100);
    csr_write(12'h300, 32'hFFFF_FFFF);
    chk("mstatus_mask", bus.csr_mstatus_o, 32'h88);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    cycle();

    // Reset mid-run drops the redirect strobe and clears all CSRs at once
    bus.x_valid_i = 1'b1;
    bus.x_exception_i = 1'b1;
    #1;
    chk("pre_rst_redirect", 32'(bus.x_redirect_o), 32'h1);
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("rst_redirect", 32'(bus.x_redirect_o), 32'h0);
    chk("rst_mepc", bus.csr_mepc_o, 32'h0);
    chk_csrs("midrst");
    @(negedge clk);
    clear_inputs();
    rst_i = 1'b1;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.x_stall_i           = ($urandom_range(0, 4) == 0);
      bus.x_kill_i            = ($urandom_range(0, 9) == 0);
      bus.x_valid_i           = ($urandom_range(0, 3) != 0);
      bus.x_pc_i              = $urandom;
      bus.x_exception_i       = ($urandom_range(0, 7) == 0);
      bus.x_exception_cause_i = 4'($urandom);
      bus.x_is_mret_i         = ($urandom_range(0, 7) == 0);
      bus.d_is_csr_i          = ($urandom_range(0, 2) == 0);
      bus.d_csr_sel_i         = sels[$urandom_range(0, 5)];
      bus.x_csr_write_value_i = $urandom;
      if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
